// File: rtl/mem_access_unit.sv
// Memory-stage load/store unit: formats byte enables and lane data for one data-memory
// request at a time and stalls the pipeline until the memory reports completion.
module mem_access_unit #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [ADDRESS_WIDTH-1:0] alu_resultM_i,
    input  logic [DATA_WIDTH-1:0]    write_dataM_i,
    input  logic                     mem_writeM_i,
    input  logic [1:0]               result_srcM_i,
    input  logic [2:0]               funct3M_i,
    output logic                     mem_req_o,
    output logic                     mem_we_o,
    output logic [ADDRESS_WIDTH-1:0] mem_addr_o,
    output logic [3:0]               mem_be_o,
    output logic [DATA_WIDTH-1:0]    mem_wdata_o,
    input  logic                     mem_ready_i,
    input  logic [DATA_WIDTH-1:0]    mem_rdata_i,
    output logic [DATA_WIDTH-1:0]    read_dataM_o,
    output logic                     stallM_o,
    output logic                     access_errM_o
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t                   state_q;
    logic                     mem_req_q;
    logic                     mem_we_q;
    logic [ADDRESS_WIDTH-1:0] mem_addr_q;
    logic [3:0]               mem_be_q;
    logic [DATA_WIDTH-1:0]    mem_wdata_q;
    logic [DATA_WIDTH-1:0]    read_data_q;
    logic [2:0]               funct3_q;
    logic [1:0]               offset_q;
    logic                     is_load_q;

    logic                     is_store;
    logic                     is_load;
    logic                     access;
    logic                     access_err;
    logic [1:0]               offset;
    logic [3:0]               be_d;
    logic [DATA_WIDTH-1:0]    wdata_d;
    logic [7:0]               lane_byte;
    logic [15:0]              lane_half;
    logic [DATA_WIDTH-1:0]    load_ext;

    // A store takes priority when both request flags are raised.
    assign is_store = mem_writeM_i;
    assign is_load  = (result_srcM_i == 2'b01) && !mem_writeM_i;
    assign access   = is_store || is_load;
    assign offset   = alu_resultM_i[1:0];

    always_comb begin
        access_err = 1'b0;
        if (is_store) begin
            case (funct3M_i)
                3'b000:  access_err = 1'b0;
                3'b001:  access_err = offset[0];
                3'b010:  access_err = (offset != 2'b00);
                default: access_err = 1'b1;
            endcase
        end else if (is_load) begin
            case (funct3M_i)
                3'b000, 3'b100: access_err = 1'b0;
                3'b001, 3'b101: access_err = offset[0];
                3'b010:         access_err = (offset != 2'b00);
                default:        access_err = 1'b1;
            endcase
        end
    end

    always_comb begin
        be_d    = 4'b1111;
        wdata_d = write_dataM_i;
        case (funct3M_i[1:0])
            2'b00: begin
                be_d    = 4'b0001 << offset;
                wdata_d = {4{write_dataM_i[7:0]}};
            end
            2'b01: begin
                be_d    = 4'b0011 << {offset[1], 1'b0};
                wdata_d = {2{write_dataM_i[15:0]}};
            end
            default: begin
                be_d    = 4'b1111;
                wdata_d = write_dataM_i;
            end
        endcase
    end

    // Lane selection uses the offset and size captured at issue, not the live M-stage inputs.
    always_comb begin
        lane_byte = mem_rdata_i[{offset_q, 3'b000} +: 8];
        lane_half = offset_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
        case (funct3_q)
            3'b000:  load_ext = {{24{lane_byte[7]}}, lane_byte};
            3'b001:  load_ext = {{16{lane_half[15]}}, lane_half};
            3'b100:  load_ext = {24'h000000, lane_byte};
            3'b101:  load_ext = {16'h0000, lane_half};
            default: load_ext = mem_rdata_i;
        endcase
    end

    assign stallM_o      = !rst_i && ((state_q == BUSY) ||
                           ((state_q == IDLE) && access && !access_err));
    assign access_errM_o = !rst_i && (state_q == IDLE) && access && access_err;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= 4'b0000;
            mem_wdata_q <= '0;
            read_data_q <= '0;
            funct3_q    <= 3'b000;
            offset_q    <= 2'b00;
            is_load_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (access && !access_err) begin
                        mem_addr_q  <= {alu_resultM_i[ADDRESS_WIDTH-1:2], 2'b00};
                        mem_be_q    <= be_d;
                        mem_wdata_q <= wdata_d;
                        mem_we_q    <= is_store;
                        mem_req_q   <= 1'b1;
                        funct3_q    <= funct3M_i;
                        offset_q    <= offset;
                        is_load_q   <= is_load;
                        state_q     <= BUSY;
                    end
                end
                BUSY: begin
                    if (mem_ready_i) begin
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                        if (is_load_q) begin
                            read_data_q <= load_ext;
                        end
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    // The pipeline advances this cycle, so never re-examine the held inputs.
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign mem_req_o    = mem_req_q;
    assign mem_we_o     = mem_we_q;
    assign mem_addr_o   = mem_addr_q;
    assign mem_be_o     = mem_be_q;
    assign mem_wdata_o  = mem_wdata_q;
    assign read_dataM_o = read_data_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Testbench for mem_access_unit: directed scenarios plus randomized accesses checked
// against an arithmetic reference model of lane formatting, extension and latency.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] aluResult;
    logic [31:0] writeData;
    logic        memWrite;
    logic [1:0]  resultSrc;
    logic [2:0]  funct3;
    logic        memReq;
    logic        memWe;
    logic [31:0] memAddr;
    logic [3:0]  memBe;
    logic [31:0] memWdata;
    logic        memReady;
    logic [31:0] memRdata;
    logic [31:0] readData;
    logic        stall;
    logic        accessErr;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] expReadData = 32'h0;

    always #5 clk = ~clk;

    mem_access_unit #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .alu_resultM_i (aluResult),
        .write_dataM_i (writeData),
        .mem_writeM_i  (memWrite),
        .result_srcM_i (resultSrc),
        .funct3M_i     (funct3),
        .mem_req_o     (memReq),
        .mem_we_o      (memWe),
        .mem_addr_o    (memAddr),
        .mem_be_o      (memBe),
        .mem_wdata_o   (memWdata),
        .mem_ready_i   (memReady),
        .mem_rdata_i   (memRdata),
        .read_dataM_o  (readData),
        .stallM_o      (stall),
        .access_errM_o (accessErr)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] modelLoad(input logic [31:0] word, input int off,
                                              input int f3);
        int unsigned b;
        int unsigned h;
        b = (word >> (8 * off)) & 32'hFF;
        h = (word >> (16 * (off / 2))) & 32'hFFFF;
        case (f3)
            0:       return (b >= 128) ? b + 32'hFFFFFF00 : b;
            1:       return (h >= 32768) ? h + 32'hFFFF0000 : h;
            4:       return b;
            5:       return h;
            default: return word;
        endcase
    endfunction

    function automatic bit modelError(input bit st, input bit ld, input int f3, input int off);
        if (st) begin
            if (f3 > 2) return 1'b1;
        end else if (ld) begin
            if (f3 == 3 || f3 == 6 || f3 == 7) return 1'b1;
        end else begin
            return 1'b0;
        end
        if ((f3 % 4) == 1 && (off % 2) == 1) return 1'b1;
        if ((f3 % 4) == 2 && off != 0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [3:0] modelBe(input int f3, input int off);
        case (f3 % 4)
            0:       return 4'(1 << off);
            1:       return 4'(3 << off);
            default: return 4'hF;
        endcase
    endfunction

    function automatic logic [31:0] modelWdata(input int f3, input logic [31:0] wd);
        case (f3 % 4)
            0:       return (wd & 32'hFF) * 32'h01010101;
            1:       return (wd & 32'hFFFF) * 32'h00010001;
            default: return wd;
        endcase
    endfunction

    task automatic clearInputs();
        memWrite  = 1'b0;
        resultSrc = 2'b00;
    endtask

    // Entered and left one time unit after a rising edge with the unit in IDLE.
    task automatic applyStimulus(input string tag, input bit isStore, input bit isLoad,
                                 input logic [2:0] f3, input logic [31:0] addr,
                                 input logic [31:0] wd, input logic [31:0] rd,
                                 input int waits);
        bit  st;
        bit  ld;
        bit  expErr;
        int  off;
        int  stallCount;
        int  busyIdx;
        bit  timedOut;
        int  pick;
        st  = isStore;
        ld  = isLoad && !isStore;
        off = int'(addr % 4);
        expErr = modelError(st, ld, int'(f3), off);

        memWrite = isStore;
        if (isLoad) begin
            resultSrc = 2'b01;
        end else begin
            pick = $urandom_range(0, 2);
            resultSrc = (pick == 0) ? 2'b00 : ((pick == 1) ? 2'b10 : 2'b11);
        end
        funct3    = f3;
        aluResult = addr;
        writeData = wd;
        memRdata  = rd;
        memReady  = 1'($urandom % 2);

        @(negedge clk);
        checkOutput({tag, "/stallIdle"}, 32'(stall), 32'((st || ld) && !expErr));
        checkOutput({tag, "/err"}, 32'(accessErr), 32'((st || ld) && expErr));

        if (!(st || ld) || expErr) begin
            @(posedge clk);
            #1;
            clearInputs();
            @(negedge clk);
            checkOutput({tag, "/noReq"}, 32'(memReq), 32'h0);
            checkOutput({tag, "/rdHeld"}, readData, expReadData);
            @(posedge clk);
            #1;
        end else begin
            stallCount = 1;
            busyIdx    = 0;
            timedOut   = 1'b0;
            forever begin
                @(posedge clk);
                #1;
                memReady = (busyIdx >= waits);
                @(negedge clk);
                if (!stall) break;
                stallCount++;
                checkOutput({tag, "/req"}, 32'(memReq), 32'h1);
                checkOutput({tag, "/we"}, 32'(memWe), 32'(st));
                checkOutput({tag, "/addr"}, memAddr, addr & 32'hFFFFFFFC);
                checkOutput({tag, "/be"}, 32'(memBe), 32'(modelBe(int'(f3), off)));
                if (st) checkOutput({tag, "/wdata"}, memWdata, modelWdata(int'(f3), wd));
                busyIdx++;
                if (busyIdx > waits + 8) begin
                    timedOut = 1'b1;
                    checks++;
                    failures++;
                    $error("[TB] FAIL %s/timeout observed=stalled expected=done", tag);
                    break;
                end
            end
            if (!timedOut) begin
                if (ld) expReadData = modelLoad(rd, off, int'(f3));
                checkOutput({tag, "/stallCycles"}, 32'(stallCount), 32'(waits + 2));
                checkOutput({tag, "/doneReq"}, 32'(memReq), 32'h0);
                checkOutput({tag, "/doneWe"}, 32'(memWe), 32'h0);
                checkOutput({tag, "/readData"}, readData, expReadData);
            end
            @(posedge clk);
            #1;
            clearInputs();
            memReady = 1'($urandom % 2);
            @(negedge clk);
            checkOutput({tag, "/noReissue"}, 32'(memReq), 32'h0);
            checkOutput({tag, "/idleStall"}, 32'(stall), 32'h0);
            @(posedge clk);
            #1;
            memReady = 1'b0;
        end
    endtask

    initial begin
        logic [2:0]  rf3;
        logic [31:0] raddr;
        int          kind;

        rst       = 1'b1;
        memReady  = 1'b1;
        memRdata  = 32'hFFFFFFFF;
        writeData = 32'h0;
        memWrite  = 1'b0;
        resultSrc = 2'b01;
        funct3    = 3'b010;
        aluResult = 32'h106;
        @(negedge clk);
        checkOutput("rstErr", 32'(accessErr), 32'h0);
        checkOutput("rstStallErrAcc", 32'(stall), 32'h0);
        aluResult = 32'h104;
        @(negedge clk);
        checkOutput("rstStall", 32'(stall), 32'h0);
        checkOutput("rstReq", 32'(memReq), 32'h0);
        checkOutput("rstWe", 32'(memWe), 32'h0);
        checkOutput("rstBe", 32'(memBe), 32'h0);
        checkOutput("rstAddr", memAddr, 32'h0);
        checkOutput("rstWdata", memWdata, 32'h0);
        checkOutput("rstReadData", readData, 32'h0);
        rst = 1'b0;
        clearInputs();
        memReady = 1'b0;
        @(posedge clk);
        #1;

        applyStimulus("lw104", 1'b0, 1'b1, 3'b010, 32'h104, 32'h0, 32'hDEADBEEF, 0);
        checkOutput("lw104/value", readData, 32'hDEADBEEF);
        applyStimulus("lb203", 1'b0, 1'b1, 3'b000, 32'h203, 32'h0, 32'h80FFFFFF, 0);
        checkOutput("lb203/value", readData, 32'hFFFFFF80);
        applyStimulus("lbu203", 1'b0, 1'b1, 3'b100, 32'h203, 32'h0, 32'h80FFFFFF, 1);
        checkOutput("lbu203/value", readData, 32'h00000080);
        applyStimulus("sh102", 1'b1, 1'b0, 3'b001, 32'h102, 32'h1234ABCD, 32'h55555555, 0);
        checkOutput("sh102/rdUnchanged", readData, 32'h00000080);
        applyStimulus("lw106", 1'b0, 1'b1, 3'b010, 32'h106, 32'h0, 32'h12345678, 0);
        applyStimulus("swWait", 1'b1, 1'b0, 3'b010, 32'h400, 32'hCAFEF00D, 32'h0, 2);
        applyStimulus("storeWins", 1'b1, 1'b1, 3'b000, 32'h501, 32'h000000A5, 32'h11111111, 1);
        applyStimulus("lh102", 1'b0, 1'b1, 3'b001, 32'h102, 32'h0, 32'h8001FFFF, 0);
        applyStimulus("lhu102", 1'b0, 1'b1, 3'b101, 32'h102, 32'h0, 32'h8001FFFF, 0);
        applyStimulus("badLoad3", 1'b0, 1'b1, 3'b011, 32'h100, 32'h0, 32'h0, 0);
        applyStimulus("badStore4", 1'b1, 1'b0, 3'b100, 32'h100, 32'h0, 32'h0, 0);
        applyStimulus("noAccess", 1'b0, 1'b0, 3'b010, 32'h100, 32'h0, 32'h0, 0);

        for (int i = 0; i < 60; i++) begin
            kind  = $urandom_range(0, 3);
            rf3   = 3'($urandom % 8);
            raddr = $urandom;
            if (($urandom % 2) == 0) raddr[1:0] = 2'b00;
            applyStimulus($sformatf("rand%0d", i), kind[1], kind[0], rf3, raddr,
                          $urandom, $urandom, $urandom_range(0, 3));
        end

        applyStimulus("preRst", 1'b0, 1'b1, 3'b010, 32'h300, 32'h0, 32'h5A5A5A5A, 0);
        checkOutput("preRst/value", readData, 32'h5A5A5A5A);
        memWrite  = 1'b0;
        resultSrc = 2'b01;
        funct3    = 3'b010;
        aluResult = 32'h308;
        memRdata  = 32'h77777777;
        memReady  = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rstBusy/stall", 32'(stall), 32'h0);
        checkOutput("rstBusy/err", 32'(accessErr), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        clearInputs();
        memReady = 1'b1;
        expReadData = 32'h0;
        @(negedge clk);
        checkOutput("rstBusy/req", 32'(memReq), 32'h0);
        checkOutput("rstBusy/readData", readData, 32'h0);
        checkOutput("rstBusy/stallAfter", 32'(stall), 32'h0);
        @(posedge clk);
        #1;
        memReady = 1'b0;
        @(negedge clk);
        checkOutput("rstBusy/lateReady", readData, 32'h0);
        checkOutput("rstBusy/reqLate", 32'(memReq), 32'h0);
        @(posedge clk);
        #1;
        applyStimulus("postRst", 1'b0, 1'b1, 3'b001, 32'h306, 32'h0, 32'h7FFF1234, 0);
        checkOutput("postRst/value", readData, 32'h00007FFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
